// File: rtl/stage_mem.sv
// Memory pipeline stage: aligns loads/stores onto a 32-bit word bus with a
// busy handshake, per-request timeout, and load extraction/extension.
`timescale 1ns/1ps
module stage_mem #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_isValid,
  input  logic [31:0] i_result,
  input  logic [31:0] i_dataB,
  input  logic        i_memWrEnable,
  input  logic        i_memRdEnable,
  input  logic [1:0]  i_memAccess,
  input  logic        i_memUnsigned,
  output logic [31:0] o_busAddr,
  output logic [31:0] o_busWrData,
  output logic [3:0]  o_busByteEn,
  output logic        o_busWr,
  output logic        o_busRd,
  input  logic [31:0] i_busRdData,
  input  logic        i_busBusy,
  output logic [31:0] o_rdData,
  output logic        o_rdValid,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_busError
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_q, state_d;
  logic              wr_q, rd_q, rdvld_q, err_q, uns_q;
  logic [1:0]        off_q, size_q;
  logic [3:0]        be_q;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_any, aligned, accept, done, tmo;

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] off, input logic uns);
    logic [31:0]        sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    sh  = word >> {off, 3'b000};
    b_s = sh[7:0];
    h_s = sh[15:0];
    case (sz)
      2'd0:    return uns ? 32'(sh[7:0])  : 32'(b_s);
      2'd1:    return uns ? 32'(sh[15:0]) : 32'(h_s);
      default: return sh;
    endcase
  endfunction

  always_comb begin
    req_any      = i_memWrEnable | i_memRdEnable;
    aligned      = is_aligned(i_memAccess, i_result[1:0]);
    accept       = ~i_reset & (state_q == IDLE) & i_isValid & req_any & aligned;
    o_misaligned = ~i_reset & (state_q == IDLE) & i_isValid & req_any & ~aligned;
    done         = (state_q == REQ) & ~i_busBusy;
    tmo          = (state_q == REQ) & i_busBusy & (cnt_q == CNT_LAST);
    o_stall      = accept | (~i_reset & (state_q == REQ));
    state_d      = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (done | tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request register stage: bus-facing outputs and load result come from flops
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      be_q    <= 4'b0000;
      rdvld_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      rdvld_q <= done & rd_q;
      err_q   <= tmo;
      if (accept) begin
        addr_q  <= {i_result[31:2], 2'b00};
        off_q   <= i_result[1:0];
        size_q  <= i_memAccess;
        uns_q   <= i_memUnsigned;
        wdata_q <= lane_data(i_memAccess, i_dataB);
        be_q    <= lane_en(i_memAccess, i_result[1:0]);
        wr_q    <= i_memWrEnable;
        rd_q    <= ~i_memWrEnable;
        cnt_q   <= '0;
      end else if (done | tmo) begin
        wr_q <= 1'b0;
        rd_q <= 1'b0;
      end else if (state_q == REQ) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (done & rd_q) rdata_q <= load_extract(i_busRdData, size_q, off_q, uns_q);
    end
  end

  assign o_busAddr   = addr_q;
  assign o_busWrData = wdata_q;
  assign o_busByteEn = be_q;
  assign o_busWr     = wr_q;
  assign o_busRd     = rd_q;
  assign o_rdData    = rdata_q;
  assign o_rdValid   = rdvld_q;
  assign o_busError  = err_q;

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: expected bus transactions and load results
// are queued at issue and compared when the DUT completes them.
`timescale 1ns/1ps
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        i_reset, i_isValid, i_memWrEnable, i_memRdEnable, i_memUnsigned, i_busBusy;
  logic [31:0] i_result, i_dataB, i_busRdData;
  logic [1:0]  i_memAccess;
  logic [31:0] o_busAddr, o_busWrData, o_rdData;
  logic [3:0]  o_busByteEn;
  logic        o_busWr, o_busRd, o_rdValid, o_stall, o_misaligned, o_busError;

  always #5 clk = ~clk;

  stage_mem #(.TIMEOUT_CYCLES(4)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_isValid(i_isValid), .i_result(i_result),
    .i_dataB(i_dataB), .i_memWrEnable(i_memWrEnable), .i_memRdEnable(i_memRdEnable),
    .i_memAccess(i_memAccess), .i_memUnsigned(i_memUnsigned), .o_busAddr(o_busAddr),
    .o_busWrData(o_busWrData), .o_busByteEn(o_busByteEn), .o_busWr(o_busWr), .o_busRd(o_busRd),
    .i_busRdData(i_busRdData), .i_busBusy(i_busBusy), .o_rdData(o_rdData), .o_rdValid(o_rdValid),
    .o_stall(o_stall), .o_misaligned(o_misaligned), .o_busError(o_busError)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] rd_exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd0) begin
      case (off)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (sz == 2'd1) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (sz == 2'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [1:0] sz, input logic [1:0] off,
                                         input logic uns, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = (off == 2'd0) ? w[7:0] : (off == 2'd1) ? w[15:8] : (off == 2'd2) ? w[23:16] : w[31:24];
    h = off[1] ? w[31:16] : w[15:0];
    if (sz == 2'd0) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'd1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  // Completion monitor: pops the scoreboard whenever the DUT finishes something
  always @(negedge clk) begin
    bus_t        e;
    logic [31:0] r;
    if (!i_reset && (o_busWr || o_busRd) && !i_busBusy) begin
      if (bus_q.size() == 0) begin
        check("unexpected_strobe", {30'h0, o_busWr, o_busRd}, 32'h0);
      end else begin
        e = bus_q.pop_front();
        check("bus_wr", 32'(o_busWr), 32'(e.wr));
        check("bus_rd", 32'(o_busRd), 32'(!e.wr));
        check("bus_addr", o_busAddr, e.addr);
        check("bus_be", 32'(o_busByteEn), 32'(e.be));
        if (e.wr) check("bus_wdata", o_busWrData, e.wd);
      end
    end
    if (o_rdValid) begin
      if (rd_exp_q.size() == 0) begin
        check("unexpected_rdvalid", 32'(o_rdValid), 32'h0);
      end else begin
        r = rd_exp_q.pop_front();
        check("rd_data", o_rdData, r);
      end
    end
  end

  task automatic drive(input logic wr, input logic rd, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data, input logic [31:0] word);
    i_isValid = 1'b1;  i_memWrEnable = wr; i_memRdEnable = rd;
    i_memAccess = sz;  i_memUnsigned = uns; i_result = addr;
    i_dataB = data;    i_busRdData = word;
  endtask

  // Issues one access, holds it while stalled, and releases it after RESP
  task automatic access(input string tag, input logic wr, input logic rd, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] word, input int busy);
    bus_t e;
    int   stalls, strobes;
    e.wr = wr; e.addr = {addr[31:2], 2'b00}; e.be = exp_be(sz, addr[1:0]); e.wd = exp_wd(sz, data);
    bus_q.push_back(e);
    if (!wr) rd_exp_q.push_back(exp_ld(sz, addr[1:0], uns, word));
    drive(wr, rd, sz, uns, addr, data, word);
    i_busBusy = (busy > 0);
    stalls = 0; strobes = 0;
    @(negedge clk);
    if (o_stall) stalls++;
    check({tag, "_misaligned"}, 32'(o_misaligned), 32'h0);
    for (int c = 0; c <= busy; c++) begin
      @(posedge clk); #1;
      i_busBusy = (c < busy);
      @(negedge clk);
      if (o_stall) stalls++;
      if (o_busWr || o_busRd) strobes++;
    end
    @(posedge clk); #1;
    i_busBusy = 1'b0;
    @(negedge clk);
    check({tag, "_resp_stall"}, 32'(o_stall), 32'h0);
    check({tag, "_resp_strobe"}, {30'h0, o_busWr, o_busRd}, 32'h0);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(busy + 2));
    check({tag, "_strobe_cycles"}, 32'(strobes), 32'(busy + 1));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    i_isValid = 1'b0; i_memWrEnable = 1'b0; i_memRdEnable = 1'b0; i_busBusy = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int strobes;
    i_reset = 1'b1; i_isValid = 1'b0; i_memWrEnable = 1'b0; i_memRdEnable = 1'b0;
    i_memAccess = 2'd0; i_memUnsigned = 1'b0; i_result = 32'h0; i_dataB = 32'h0;
    i_busRdData = 32'h0; i_busBusy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {30'h0, o_busWr, o_busRd}, 32'h0);
    check("rst_be", 32'(o_busByteEn), 32'h0);
    check("rst_flags", {29'h0, o_rdValid, o_stall, o_busError}, 32'h0);
    check("rst_rddata", o_rdData, 32'h0);
    check("rst_addr", o_busAddr, 32'h0);
    check("rst_wdata", o_busWrData, 32'h0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    idle(1);

    access("ldb_signed", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0);
    access("sth_busy3",  1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3);
    // Back-to-back: each call releases the previous instruction and presents the next
    access("ldh_uns",    1'b0, 1'b1, 2'd1, 1'b1, 32'h0000_4002, 32'h0, 32'h8765_4321, 0);
    access("ldh_sgn",    1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_4000, 32'h0, 32'h1234_F00D, 1);
    access("ldw_rsvd",   1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_4008, 32'h0, 32'hDEAD_BEEF, 2);
    access("stb_both",   1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_5001, 32'h1234_56A5, 32'h0, 0);
    access("ldb_uns",    1'b0, 1'b1, 2'd0, 1'b1, 32'h0000_5002, 32'h0, 32'h00C3_0000, 1);
    idle(2);
    @(negedge clk);
    check("rddata_hold", o_rdData, 32'h0000_00C3);
    @(posedge clk); #1;

    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 32'h0);
    @(negedge clk);
    check("mis_word_pulse", 32'(o_misaligned), 32'h1);
    check("mis_word_stall", 32'(o_stall), 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_3003, 32'h1111_2222, 32'h0);
    @(negedge clk);
    check("mis_half_pulse", 32'(o_misaligned), 32'h1);
    check("mis_word_nostrobe", {30'h0, o_busWr, o_busRd}, 32'h0);
    idle(1);
    @(negedge clk);
    check("mis_half_nostrobe", {30'h0, o_busWr, o_busRd}, 32'h0);
    check("mis_clear", 32'(o_misaligned), 32'h0);
    @(posedge clk); #1;

    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_6000, 32'h0, 32'h5555_5555);
    i_busBusy = 1'b1;
    strobes = 0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (o_busRd) strobes++;
    end
    check("tmo_strobe_cycles", 32'(strobes), 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    check("tmo_error", 32'(o_busError), 32'h1);
    check("tmo_rdvalid", 32'(o_rdValid), 32'h0);
    check("tmo_strobe_drop", {30'h0, o_busWr, o_busRd}, 32'h0);
    check("tmo_stall", 32'(o_stall), 32'h0);
    check("tmo_rddata_hold", o_rdData, 32'h0000_00C3);
    idle(1);
    @(negedge clk);
    check("tmo_error_pulse", 32'(o_busError), 32'h0);
    @(posedge clk); #1;
    access("post_tmo", 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_6004, 32'h0, 32'h0BAD_F00D, 0);
    idle(1);

    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_7000, 32'h0, 32'h0);
    i_busBusy = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_strobe_before", 32'(o_busRd), 32'h1);
    @(posedge clk); #1;
    i_reset = 1'b1;
    i_isValid = 1'b0; i_memRdEnable = 1'b0; i_busBusy = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    check("rstmid_strobe", {30'h0, o_busWr, o_busRd}, 32'h0);
    check("rstmid_stall", 32'(o_stall), 32'h0);
    check("rstmid_addr", o_busAddr, 32'h0);
    check("rstmid_rddata", o_rdData, 32'h0);
    idle(2);
    @(negedge clk);
    check("rstmid_no_rdvalid", 32'(o_rdValid), 32'h0);
    @(posedge clk); #1;
    access("post_rst", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_7004, 32'hCAFE_0001, 32'h0, 1);
    idle(2);

    check("bus_q_empty", 32'(bus_q.size()), 32'h0);
    check("rd_q_empty", 32'(rd_exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
